// File: rtl/spart_tx_param.sv
// SPART UART transmitter: start, DATA_W data bits LSB first, optional parity, 1-2 stop bits; OSR en ticks per bit.
// Define SPART_TX_FIFO_EN for a 4-entry write FIFO with back-to-back frames; otherwise a single holding register.
module spart_tx_param #(
  parameter int DATA_W      = 8,
  parameter int OSR         = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              en,
  input  logic              en_start,
  output logic              tbr,
  output logic              TxD,
  output logic              busy
);

  // Out-of-range settings fall back to no parity and one stop bit.
  localparam int PAR_EFF  = (PARITY_MODE == 1 || PARITY_MODE == 2) ? PARITY_MODE : 0;
  localparam int STOP_EFF = (STOP_BITS == 2) ? 2 : 1;
  localparam int TW = $clog2(OSR);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] TICK_MAX  = TW'(OSR - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_EFF - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              txd_q, txd_d;
  logic              load;
  logic              idle_ld, chain_ld;
  logic [DATA_W-1:0] ld_dat;

`ifdef SPART_TX_FIFO_EN
  logic [DATA_W-1:0] fifo_q [4];
  logic [1:0]        wr_ptr_q, rd_ptr_q;
  logic [2:0]        cnt_q;
  logic              push;

  assign tbr      = (cnt_q != 3'd4);
  assign push     = en_start & tbr;
  assign idle_ld  = (cnt_q != 3'd0);
  assign chain_ld = (cnt_q != 3'd0);
  assign ld_dat   = fifo_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (load) rd_ptr_q <= rd_ptr_q + 2'd1;
      if (push && !load)      cnt_q <= cnt_q + 3'd1;
      else if (!push && load) cnt_q <= cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= data;
  end
`else
  assign tbr      = (state_q == IDLE);
  assign idle_ld  = en_start;
  assign chain_ld = 1'b0;
  assign ld_dat   = data;
`endif

  assign TxD  = txd_q;
  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    load    = 1'b0;
    if (state_q == IDLE) begin
      load = idle_ld;
    end else if (en) begin
      if (tick_q != '0) begin
        tick_d = tick_q - 1'b1;
      end else begin
        tick_d = TICK_MAX;
        case (state_q)
          START: begin
            state_d = DATA;
            bit_d   = '0;
            txd_d   = shift_q[0];
          end
          DATA: begin
            shift_d = shift_q >> 1;
            if (bit_q == LAST_DATA) begin
              bit_d = '0;
              if (PAR_EFF != 0) begin
                state_d = PARITY;
                txd_d   = par_q;
              end else begin
                state_d = STOP;
                txd_d   = 1'b1;
              end
            end else begin
              bit_d = bit_q + 1'b1;
              txd_d = shift_q[1];
            end
          end
          PARITY: begin
            state_d = STOP;
            bit_d   = '0;
            txd_d   = 1'b1;
          end
          STOP: begin
            // Last stop tick: chain straight into the next START if a word is waiting.
            if (bit_q == LAST_STOP) begin
              if (chain_ld) begin
                load = 1'b1;
              end else begin
                state_d = IDLE;
                txd_d   = 1'b1;
              end
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
          default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        endcase
      end
    end
    if (load) begin
      shift_d = ld_dat;
      par_d   = (^ld_dat) ^ (PAR_EFF == 2);
      state_d = START;
      tick_d  = TICK_MAX;
      bit_d   = '0;
      txd_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

endmodule
